// File: rtl/sink_arb_pkg.sv
// Shared types and flit field layout for the sink-port arbiter.
package sink_arb_pkg;

    // Sequence id carried in every flit.
    typedef logic [7:0] id_t;

    localparam int unsigned ID_W    = 8;
    localparam int unsigned CNT_W   = 16;
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    // MSB position of each flit field. The layout from the top is:
    // src, dst, id, data.
    function automatic int unsigned src_pos(int unsigned width, int unsigned naddr);
        return width - 1 + (naddr - naddr);
    endfunction

    function automatic int unsigned dst_pos(int unsigned width, int unsigned naddr);
        return width - 1 - naddr;
    endfunction

    function automatic int unsigned id_pos(int unsigned width, int unsigned naddr);
        return width - 1 - 2 * naddr;
    endfunction

    function automatic int unsigned data_pos(int unsigned width, int unsigned naddr);
        return width - 1 - 2 * naddr - ID_W;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first asserted request at or after ptr, wrapping at K-1.
module rr_arbiter #(
    parameter int unsigned K       = 4,
    parameter int unsigned K_WIDTH = $clog2(K)
) (
    input  logic [K-1:0]       req,
    input  logic [K_WIDTH-1:0] ptr,
    output logic [K-1:0]       gnt,
    output logic [K_WIDTH-1:0] gnt_idx,
    output logic               any
);

    // Rotating priority search; only the first hit is granted.
    always_comb begin
        int unsigned idx;
        logic        found;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int unsigned off = 0; off < K; off++) begin
            idx = (int'(ptr) + off) % K;
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = K_WIDTH'(idx);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/sink_arb.sv
// K-to-1 sink-port arbiter with a one-entry output register, per-requester
// id-sequence checking and saturating accepted-flit counters.
module sink_arb
    import sink_arb_pkg::*;
#(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned N            = 16,
    parameter int unsigned N_ADDR_WIDTH = $clog2(N),
    parameter int unsigned K            = 4,
    parameter int unsigned K_WIDTH      = $clog2(K)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [K*WIDTH-1:0]   in_data,
    input  logic [K-1:0]         in_valid,
    output logic [K-1:0]         in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [K_WIDTH-1:0]   grant_idx,
    output logic [K-1:0]         id_err,
    output logic [K*CNT_W-1:0]   pkt_cnt
);

    // Fall back to the node-count width if the address width is overridden to zero.
    localparam int unsigned NADDR    = (N_ADDR_WIDTH > 0) ? N_ADDR_WIDTH : $clog2(N);
    localparam int unsigned SRC_POS  = src_pos(WIDTH, NADDR);
    localparam int unsigned DST_POS  = dst_pos(WIDTH, NADDR);
    localparam int unsigned ID_POS   = id_pos(WIDTH, NADDR);
    localparam int unsigned DATA_POS = data_pos(WIDTH, NADDR);

    // State
    logic [K_WIDTH-1:0] ptr_q, ptr_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic [K_WIDTH-1:0] grant_idx_q, grant_idx_d;
    logic [K-1:0]       seen_q, seen_d;
    id_t                exp_q [K];
    id_t                exp_d [K];
    logic [K-1:0]       id_err_q, id_err_d;
    logic [CNT_W-1:0]   cnt_q [K];
    logic [CNT_W-1:0]   cnt_d [K];

    // Arbitration
    logic [K-1:0]       gnt;
    logic [K_WIDTH-1:0] gnt_idx;
    logic               any_req;
    logic               can_load;
    logic               accept;

    logic [WIDTH-1:0]   in_flit [K];
    logic [WIDTH-1:0]   sel_flit;
    logic [NADDR-1:0]   sel_src;
    logic [NADDR-1:0]   sel_dst;
    id_t                sel_id;
    logic [DATA_POS:0]  sel_data;

    rr_arbiter #(
        .K       (K),
        .K_WIDTH (K_WIDTH)
    ) u_rr_arbiter (
        .req     (in_valid),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any_req)
    );

    assign can_load = !out_valid_q || out_ready;
    // Reset blocks every handshake so nothing is consumed while state is cleared.
    assign accept   = can_load && any_req && !rst;
    assign in_ready = accept ? gnt : '0;

    // Split the flat input bus into per-requester flits.
    always_comb begin
        for (int unsigned i = 0; i < K; i++) begin
            in_flit[i] = in_data[i*WIDTH +: WIDTH];
        end
    end

    assign sel_flit = in_flit[gnt_idx];
    assign sel_src  = sel_flit[SRC_POS -: NADDR];
    assign sel_dst  = sel_flit[DST_POS -: NADDR];
    assign sel_id   = sel_flit[ID_POS -: ID_W];
    assign sel_data = sel_flit[DATA_POS:0];

    // Output register and pointer next state.
    always_comb begin
        ptr_d       = ptr_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        grant_idx_d = grant_idx_q;
        if (accept) begin
            out_data_d  = {sel_src, sel_dst, sel_id, sel_data};
            out_valid_d = 1'b1;
            grant_idx_d = gnt_idx;
            ptr_d       = (gnt_idx == K_WIDTH'(K - 1)) ? '0 : gnt_idx + 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Per-requester id tracking and accept counters.
    always_comb begin
        seen_d   = seen_q;
        id_err_d = id_err_q;
        for (int unsigned i = 0; i < K; i++) begin
            exp_d[i] = exp_q[i];
            cnt_d[i] = cnt_q[i];
            if (in_ready[i]) begin
                if (seen_q[i] && (sel_id != exp_q[i])) begin
                    id_err_d[i] = 1'b1;
                end
                exp_d[i]  = sel_id + 8'd1;
                seen_d[i] = 1'b1;
                if (cnt_q[i] != CNT_MAX) begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            grant_idx_q <= '0;
            seen_q      <= '0;
            id_err_q    <= '0;
            for (int unsigned i = 0; i < K; i++) begin
                exp_q[i] <= '0;
                cnt_q[i] <= '0;
            end
        end else begin
            ptr_q       <= ptr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            grant_idx_q <= grant_idx_d;
            seen_q      <= seen_d;
            id_err_q    <= id_err_d;
            for (int unsigned i = 0; i < K; i++) begin
                exp_q[i] <= exp_d[i];
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Flatten counters onto the output bus.
    always_comb begin
        pkt_cnt = '0;
        for (int unsigned i = 0; i < K; i++) begin
            pkt_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign grant_idx = grant_idx_q;
    assign id_err    = id_err_q;

endmodule

// File: tb/tb_sink_arb.sv
// Scoreboard bench for sink_arb: a reference arbiter predicts every accept,
// pushes the expected flit and grant, and the output side pops and compares.
module tb_sink_arb;

    localparam int W = 32;
    localparam int K = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [K*W-1:0]   in_data;
    logic [K-1:0]     in_valid;
    logic [K-1:0]     in_ready;
    logic [W-1:0]     out_data;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       grant_idx;
    logic [K-1:0]     id_err;
    logic [K*16-1:0]  pkt_cnt;

    always #5 clk = ~clk;

    sink_arb #(
        .WIDTH (32),
        .N     (16),
        .K     (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .grant_idx (grant_idx),
        .id_err    (id_err),
        .pkt_cnt   (pkt_cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [1:0]   g;
        logic [W-1:0] d;
    } exp_t;

    exp_t sb[$];

    // Reference model state
    int          m_ptr;
    logic [K-1:0] m_seen;
    logic [K-1:0] m_err;
    logic [7:0]  m_exp [K];
    logic [15:0] m_cnt [K];

    // Stimulus state
    logic [7:0]  cur_id  [K];
    logic [15:0] cur_dat [K];
    bit          auto_inc;
    bit          last_acc;
    int          last_g;

    function automatic logic [W-1:0] mk(input int r, input logic [7:0] id, input logic [15:0] d);
        logic [3:0] src;
        logic [3:0] dst;
        src = 4'(r);
        dst = 4'(r + 8);
        return {src, dst, id, d};
    endfunction

    task automatic drive();
        for (int r = 0; r < K; r++) begin
            in_data[r*W +: W] = mk(r, cur_id[r], cur_dat[r]);
        end
    endtask

    task automatic model_clear();
        m_ptr  = 0;
        m_seen = '0;
        m_err  = '0;
        for (int r = 0; r < K; r++) begin
            m_exp[r] = '0;
            m_cnt[r] = '0;
        end
        sb.delete();
    endtask

    // One clock: check at the falling edge, advance the model, re-drive after the rising edge.
    task automatic tick();
        bit           can_load;
        bit           acc;
        int           g;
        logic [K-1:0] er;
        logic [63:0]  cnt_exp;
        logic [7:0]   id;
        @(negedge clk);
        g = -1;
        can_load = (sb.size() == 0) || out_ready;
        for (int o = 0; o < K; o++) begin
            int i;
            i = (m_ptr + o) % K;
            if (g < 0 && in_valid[i]) g = i;
        end
        acc = !rst && can_load && (g >= 0);
        er  = acc ? (K'(1) << g) : '0;
        check_eq("in_ready", 64'(in_ready), 64'(er));
        if (sb.size() != 0) begin
            check_eq("out_valid", 64'(out_valid), 64'd1);
            check_eq("out_data", 64'(out_data), 64'(sb[0].d));
            check_eq("grant_idx", 64'(grant_idx), 64'(sb[0].g));
        end else begin
            check_eq("out_valid_idle", 64'(out_valid), 64'd0);
        end
        check_eq("id_err", 64'(id_err), 64'(m_err));
        cnt_exp = '0;
        for (int r = 0; r < K; r++) cnt_exp[r*16 +: 16] = m_cnt[r];
        check_eq("pkt_cnt", 64'(pkt_cnt), cnt_exp);
        last_acc = acc;
        last_g   = g;
        if (rst) begin
            model_clear();
        end else begin
            if (sb.size() != 0 && out_ready) void'(sb.pop_front());
            if (acc) begin
                sb.push_back({2'(g), mk(g, cur_id[g], cur_dat[g])});
                id = cur_id[g];
                if (m_seen[g] && id != m_exp[g]) m_err[g] = 1'b1;
                m_exp[g]  = id + 8'd1;
                m_seen[g] = 1'b1;
                if (m_cnt[g] != 16'hFFFF) m_cnt[g] = m_cnt[g] + 16'd1;
                m_ptr = (g + 1) % K;
                if (auto_inc) begin
                    cur_id[g]  = cur_id[g] + 8'd1;
                    cur_dat[g] = 16'($urandom);
                end
            end
        end
        @(posedge clk);
        #1;
        drive();
    endtask

    // Present one flit with a chosen id from requester r until it is accepted.
    task automatic send(input int r, input logic [7:0] id);
        bit done;
        done       = 1'b0;
        cur_id[r]  = id;
        cur_dat[r] = 16'($urandom);
        in_valid   = K'(1) << r;
        drive();
        for (int t = 0; t < 20 && !done; t++) begin
            tick();
            if (last_acc && last_g == r) done = 1'b1;
        end
        if (!done) check_eq("send_timeout", 64'd0, 64'd1);
        in_valid = '0;
        drive();
    endtask

    initial begin
        model_clear();
        auto_inc = 1'b1;
        last_acc = 1'b0;
        last_g   = -1;
        for (int r = 0; r < K; r++) begin
            cur_id[r]  = 8'(r * 16);
            cur_dat[r] = 16'($urandom);
        end
        rst       = 1'b1;
        in_valid  = '1;
        out_ready = 1'b1;
        drive();

        // Reset with requests pending: nothing may be accepted.
        repeat (2) tick();
        rst = 1'b0;
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_out_data", 64'(out_data), 64'd0);
        check_eq("rst_grant_idx", 64'(grant_idx), 64'd0);
        check_eq("rst_id_err", 64'(id_err), 64'd0);
        check_eq("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);

        // Idle.
        in_valid = '0;
        drive();
        repeat (5) tick();

        // All requesters valid, sink always ready: 0,1,2,3,0,... back to back.
        in_valid = '1;
        drive();
        repeat (12) tick();

        // Backpressure for five cycles, then release.
        out_ready = 1'b0;
        repeat (5) tick();
        out_ready = 1'b1;
        repeat (4) tick();
        in_valid = '0;
        drive();
        repeat (2) tick();

        // Id sequencing.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        auto_inc = 1'b0;
        send(2, 8'd5);
        send(2, 8'd6);
        check_eq("id_err_in_seq", 64'(id_err), 64'd0);
        send(2, 8'd8);
        check_eq("id_err_gap", 64'(id_err), 64'b0100);
        send(1, 8'd254);
        send(1, 8'd255);
        send(1, 8'd0);
        send(1, 8'd1);
        repeat (3) tick();
        check_eq("id_err_wrap", 64'(id_err), 64'b0100);

        // Reset mid-operation with a held flit.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        auto_inc = 1'b1;
        for (int n = 0; n < 7; n++) send(0, cur_id[0]);
        out_ready = 1'b0;
        tick();
        check_eq("held_valid", 64'(out_valid), 64'd1);
        check_eq("held_cnt0", 64'(pkt_cnt[15:0]), 64'd7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("post_rst_valid", 64'(out_valid), 64'd0);
        check_eq("post_rst_cnt0", 64'(pkt_cnt[15:0]), 64'd0);
        in_valid  = '1;
        out_ready = 1'b1;
        drive();
        tick();
        check_eq("post_rst_grant", 64'(grant_idx), 64'd0);
        in_valid = '0;
        drive();
        repeat (2) tick();

        // Counter saturation on requester 3.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 4'b1000;
        drive();
        repeat (65534) tick();
        check_eq("cnt3_fffe", 64'(pkt_cnt[63:48]), 64'hFFFE);
        repeat (3) tick();
        check_eq("cnt3_sat", 64'(pkt_cnt[63:48]), 64'hFFFF);
        in_valid = '0;
        drive();
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
